// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame width and default bit period.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } uart_state_t;

endpackage

// File: rtl/uart_rx_byte_if.sv
// Byte stream out of the UART receiver: holding-register data with valid/ready handshake.
interface uart_rx_byte_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period down-counter; expire is high for the single cycle the count sits at 1.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    localparam int CW           = $clog2(CLKS_PER_BIT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          expire
);

    logic [CW-1:0] cnt_reg;

    // Expiry fires load_val cycles after the load strobe; the count then parks at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign expire = (cnt_reg == CW'(1));

endmodule

// File: rtl/uart_rx_byte.sv
// UART receiver (8N1, LSB first) with a one-entry holding register and valid/ready output.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity mismatches.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx,
    uart_rx_byte_if.master byte_if,
    output logic           busy,
    output logic           frame_err,
    output logic           overrun,
    output logic           parity_err
);

    localparam int            CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT);

    logic [SYNC_STAGES-1:0] sync_d;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rs;
    logic                   rs_prev_reg;
    logic                   fall;

    uart_state_t          state_reg, state_next;
    logic [2:0]           bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic                 valid_reg;
    logic                 overrun_reg;
    logic                 frame_err_reg, frame_err_next;
    logic                 cnt_load;
    logic [CW-1:0]        cnt_val;
    logic                 expire;
    logic                 shift_en;
    logic                 deliver;
    logic                 handshake;
    logic                 parity_bad;

    assign sync_d[0] = rx;
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
        assign sync_d[gi] = sync_reg[gi-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg    <= '1;
            rs_prev_reg <= 1'b1;
        end else begin
            sync_reg    <= sync_d;
            rs_prev_reg <= rs;
        end
    end

    assign rs   = sync_reg[SYNC_STAGES-1];
    assign fall = rs_prev_reg & ~rs;

    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .expire   (expire)
    );

`ifdef UART_RX_PARITY_EN
    logic parity_load;
    logic parity_bad_reg;
    logic parity_err_reg, parity_err_next;

    // Even parity: the received bit must equal the XOR of the data bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_bad_reg <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            if (parity_load) begin
                parity_bad_reg <= rs ^ (^shift_reg);
            end
            parity_err_reg <= parity_err_next;
        end
    end

    assign parity_bad = parity_bad_reg;
    assign parity_err = parity_err_reg;
`else
    assign parity_bad = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            bit_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            bit_idx_reg <= bit_idx_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_idx_next   = bit_idx_reg;
        cnt_load       = 1'b0;
        cnt_val        = FULL_BIT;
        shift_en       = 1'b0;
        deliver        = 1'b0;
        frame_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_load     = 1'b0;
        parity_err_next = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (fall) begin
                    cnt_load   = 1'b1;
                    cnt_val    = HALF_BIT;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (expire) begin
                    if (rs) begin
                        state_next = ST_IDLE;
                    end else begin
                        cnt_load     = 1'b1;
                        bit_idx_next = '0;
                        state_next   = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (expire) begin
                    shift_en = 1'b1;
                    cnt_load = 1'b1;
                    if (bit_idx_reg == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (expire) begin
                    parity_load = 1'b1;
                    cnt_load    = 1'b1;
                    state_next  = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (expire) begin
`ifdef UART_RX_PARITY_EN
                    parity_err_next = parity_bad;
`endif
                    if (rs) begin
                        deliver    = ~parity_bad;
                        state_next = ST_IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // Hold off until the line idles so a break never looks like a start bit.
                if (rs) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign handshake = valid_reg & byte_if.ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg     <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            if (shift_en) begin
                shift_reg[bit_idx_reg] <= rs;
            end
            frame_err_reg <= frame_err_next;
            // A new byte may replace the held one only when the held one leaves this cycle.
            if (deliver && (!valid_reg || handshake)) begin
                data_reg  <= shift_reg;
                valid_reg <= 1'b1;
            end else begin
                if (handshake) begin
                    valid_reg <= 1'b0;
                end
                if (deliver) begin
                    overrun_reg <= 1'b1;
                end
            end
        end
    end

    assign byte_if.data  = data_reg;
    assign byte_if.valid = valid_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign frame_err     = frame_err_reg;
    assign overrun       = overrun_reg;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit; received bytes are checked against a scoreboard.
module tb_uart_rx_byte;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;
    logic busy;
    logic frame_err;
    logic overrun;
    logic parity_err;

    uart_rx_byte_if byte_if ();

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_if    (byte_if),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int errors       = 0;
    int checks       = 0;
    int frame_cnt    = 0;
    int parity_cnt   = 0;
    int valid_cycles = 0;
    int hs_cnt       = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err)     frame_cnt++;
            if (parity_err)    parity_cnt++;
            if (byte_if.valid) valid_cycles++;
            if (byte_if.valid && byte_if.ready) begin
                hs_cnt++;
                check("sb_has_entry", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    $display("rx byte %02h expected %02h at %0t", byte_if.data, exp_b, $time);
                    check("sb_data", 32'(byte_if.data), 32'(exp_b));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        step(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_time(^b);
`endif
        bit_time(stop_bit);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] b, input logic par_bit);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(par_bit);
        bit_time(1'b1);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0, h0, f0, p0;
        byte_if.ready = 1'b1;
        step(5);
        check("rst_valid", 32'(byte_if.valid), 0);
        check("rst_data", 32'(byte_if.data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_parity_err", 32'(parity_err), 0);
        reset = 1'b0;
        step(2 * CPB);

        // Clean byte with ready held high
        v0 = valid_cycles;
        h0 = hs_cnt;
        exp_q.push_back(8'h2D);
        send_frame(8'h2D, 1'b1);
        bit_time(1'b1);
        step(CPB);
        check("t1_valid_cycles", valid_cycles - v0, 1);
        check("t1_handshakes", hs_cnt - h0, 1);
        check("t1_frame_err", frame_cnt, 0);
        check("t1_overrun", 32'(overrun), 0);
        check("t1_busy_idle", 32'(busy), 0);

        // Framing error followed by a 40-bit break
        f0 = frame_cnt;
        h0 = hs_cnt;
        send_frame(8'h41, 1'b0);
        rx = 1'b0;
        step(40 * CPB);
        check("t3_busy_in_break", 32'(busy), 1);
        check("t3_frame_pulses", frame_cnt - f0, 1);
        check("t3_no_delivery", hs_cnt - h0, 0);
        check("t3_valid_low", 32'(byte_if.valid), 0);
        rx = 1'b1;
        for (int i = 0; i < 20 && busy; i++) step(1);
        check("t3_busy_release", 32'(busy), 0);
        bit_time(1'b1);

        // Short low glitch on an idle line
        f0 = frame_cnt;
        h0 = hs_cnt;
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        check("t4_busy_set", 32'(busy), 1);
        for (int i = 0; i < 9 && busy; i++) step(1);
        check("t4_busy_release", 32'(busy), 0);
        bit_time(1'b1);
        check("t4_no_frame_err", frame_cnt - f0, 0);
        check("t4_no_delivery", hs_cnt - h0, 0);

        // Two back-to-back bytes while the consumer stalls
        h0 = hs_cnt;
        byte_if.ready = 1'b0;
        exp_q.push_back(8'h35);
        send_frame(8'h35, 1'b1);
        send_frame(8'h0A, 1'b1);
        bit_time(1'b1);
        step(CPB);
        check("t2_overrun_set", 32'(overrun), 1);
        check("t2_valid_held", 32'(byte_if.valid), 1);
        check("t2_data_held", 32'(byte_if.data), 32'h35);
        byte_if.ready = 1'b1;
        step(1);
        check("t2_valid_clear", 32'(byte_if.valid), 0);
        check("t2_one_handshake", hs_cnt - h0, 1);
        step(2 * CPB);
        check("t2_overrun_sticky", 32'(overrun), 1);
        check("t2_no_second_byte", hs_cnt - h0, 1);

        // Reset during data bit 3 of 0x55, then a clean 0xAA
        rx = 1'b0;
        step(CPB);
        bit_time(1'b1);
        bit_time(1'b0);
        bit_time(1'b1);
        rx = 1'b0;
        step(CPB / 2);
        reset = 1'b1;
        step(2);
        check("t5_busy_in_reset", 32'(busy), 0);
        check("t5_overrun_cleared", 32'(overrun), 0);
        check("t5_valid_in_reset", 32'(byte_if.valid), 0);
        rx = 1'b1;
        step(2);
        reset = 1'b0;
        bit_time(1'b1);
        bit_time(1'b1);
        h0 = hs_cnt;
        exp_q.push_back(8'hAA);
        send_frame(8'hAA, 1'b1);
        bit_time(1'b1);
        step(CPB);
        check("t5_one_delivery", hs_cnt - h0, 1);
        check("t5_data", 32'(byte_if.data), 32'hAA);
        check("t5_overrun", 32'(overrun), 0);

`ifdef UART_RX_PARITY_EN
        // Wrong parity discards the byte, correct parity delivers it
        p0 = parity_cnt;
        f0 = frame_cnt;
        h0 = hs_cnt;
        send_frame_par(8'h07, 1'b0);
        bit_time(1'b1);
        step(CPB);
        check("t6_parity_pulse", parity_cnt - p0, 1);
        check("t6_no_delivery", hs_cnt - h0, 0);
        check("t6_no_frame_err", frame_cnt - f0, 0);
        p0 = parity_cnt;
        exp_q.push_back(8'h07);
        send_frame_par(8'h07, 1'b1);
        bit_time(1'b1);
        step(CPB);
        check("t6_parity_ok", parity_cnt - p0, 0);
        check("t6_delivery", hs_cnt - h0, 1);
        check("t6_data", 32'(byte_if.data), 32'h07);
`else
        p0 = parity_cnt;
        check("parity_never_pulses", p0, 0);
`endif

        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
Self-contained UART receiver: 8N1, LSB first, line idle high. Samples each bit at mid-bit and delivers every received byte through a one-entry holding register with a valid/ready handshake. Serves as the receive end paired with the existing uart_tx, and replaces ad-hoc shift-register/pulse-counter receive logic in calculator top levels. Framing and overrun errors are reported to the consumer.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit period; minimum 8.
SYNC_STAGES, 2, synchronizer flops on rx; 2 or 3.

Ports:
clk  input  1  system clock (CLOCK_50 at top)
reset  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line; idle high
data  output  8  holding-register byte; stable while valid=1
valid  output  1  holding register full
ready  input  1  consumer accepts; handshake = valid & ready
busy  output  1  FSM not in IDLE
frame_err  output  1  one-cycle pulse when the stop bit samples 0
overrun  output  1  sticky: a byte was dropped because the holding register was full
parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 without UART_RX_PARITY_EN

Behaviour:
- Reset: all outputs 0; data=8'h00; FSM=IDLE; bit counter and baud counter=0; synchronizer flops=1.
- rx passes through SYNC_STAGES flops (rs). Falling-edge detect = previous rs 1 and current rs 0.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: on a falling edge, load the baud counter with CLKS_PER_BIT/2 (integer division) and go to START.
- START: when the count expires, sample rs. If rs=1, it is a glitch: return to IDLE with no error. If rs=0, reload the counter with CLKS_PER_BIT and go to DATA with bit index 0.
- DATA: at each expiry, shift rs into bit [index] (LSB first) and reload the counter. After index 7, go to STOP.
- STOP: at expiry, sample rs.
  - rs=1: deliver the byte and go to IDLE.
  - rs=0: pulse frame_err, discard the byte, and go to WAIT_IDLE.
- WAIT_IDLE: stay until rs=1, then go to IDLE. A break condition therefore never produces a spurious start.
- Delivery, on the cycle after the stop-bit sample:
  - Register empty, or a handshake in the same cycle: load data and set valid=1.
  - Register full and no handshake: keep the old byte, drop the new byte, set overrun=1.
- Handshake: valid clears on the cycle after valid & ready, unless a new byte loads in that same cycle, in which case valid stays 1 with the new data.
- overrun is cleared only by reset. It is not cleared by a handshake.
- ready while valid=0 has no effect.
- busy=1 in all states except IDLE.
- Latency: the rx stop-bit mid-sample point plus SYNC_STAGES+1 cycles gives valid.
- reset asserted mid-frame: the FSM returns to IDLE immediately and the partial byte is lost.

Optional Feature:
UART_RX_PARITY_EN:
- Defined: 8E1. A PARITY state sits between DATA and STOP and samples the even-parity bit.
- On mismatch, parity_err pulses one cycle in the STOP-decision cycle and the byte is discarded. The FSM still checks the stop bit, so frame_err may also fire.
- Undefined: there is no PARITY state and parity_err is tied 0.

Decomposition:
- Package uart_pkg holds:
  - the FSM state encoding (IDLE/START/DATA/PARITY/STOP/WAIT_IDLE);
  - DATA_BITS=8;
  - the default CLKS_PER_BIT=434.
- Sub-module uart_baud_cnt: down-counter with a load value and a load strobe, emitting a one-cycle expire pulse. Width is $clog2(CLKS_PER_BIT+1). It is reusable by uart_tx.

Test Plan:
All tests use CLKS_PER_BIT=16 and ready held 1 unless stated.
- Send 0x2D (start, bits 1,0,1,1,0,1,0,0, stop) -> data=8'h2D and valid=1 for exactly 1 cycle; frame_err=0; overrun=0.
- Send 0x35 then 0x0A back-to-back with ready=0, then raise ready -> data=8'h35 held; overrun=1; after the handshake valid=0 and 0x0A never appears.
- Send 0x41 with the stop bit driven 0, then hold rx low for 40 bit times -> frame_err pulses once; valid stays 0; busy=1 until rx returns high, then busy=0.
- Drive a 4-cycle low glitch on idle rx -> no valid and no frame_err; busy returns to 0 within 9 cycles.
- Assert reset at data bit 3 of 0x55, then send 0xAA cleanly -> only 8'hAA is delivered.
- With UART_RX_PARITY_EN: send 0x07 with a wrong parity bit (0) -> parity_err=1 and no valid. Resend with parity=1 -> data=8'h07.
